seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 115 +++++++++++
 tb/tb_seg_scan_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Purpose: time-multiplexed 8-digit seven-segment scanner; SEG_LZ_BLANK_EN enables leading-zero blanking.
// Latency: DIG/codeout follow the scan index and display register by one clk_50M cycle.
// Backpressure: none; load is a fire-and-forget strobe and new data is shown from the next frame.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk_50M,
   input  logic        clear_n,
   input  logic [31:0] bcd_in,
   input  logic        load,
   input  logic [7:0]  digit_en,
   output logic [7:0]  DIG,
   output logic [6:0]  codeout,
   output logic        frame_done
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] div_cnt;
   logic [2:0]  idx;
   logic [31:0] pending;
   logic [31:0] display;
   logic        wrap_q;
   logic        tc;
   logic        frame_tc;
   logic [3:0]  cur_code;
   logic        blank;
   logic [7:0]  dig_nxt;
   logic [6:0]  code_nxt;

   assign tc       = (div_cnt == DIV_LAST);
   assign frame_tc = tc && (idx == 3'd7);
   assign cur_code = display[{idx, 2'b00} +: 4];

   // Segment patterns a..g on [6]..[0]; codes above 9 render as a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000001;
      endcase
      return s;
   endfunction

   // Slot divider, scan index and the pending/display double buffer.
   // Display only changes at the frame boundary so a frame is never torn;
   // a load landing on that same edge bypasses pending so it is not lost a frame.
   always_ff @(posedge clk_50M) begin
      if (!clear_n) begin
         div_cnt <= '0;
         idx     <= '0;
         pending <= '0;
         display <= '0;
         wrap_q  <= 1'b0;
      end else begin
         div_cnt <= tc ? 16'd0 : div_cnt + 16'd1;
         if (tc) idx <= idx + 3'd1;
         if (load) pending <= bcd_in;
         if (frame_tc) display <= load ? bcd_in : pending;
         wrap_q  <= frame_tc;
      end
   end

`ifdef SEG_LZ_BLANK_EN
   logic [7:0] lz_mask;
   logic       lz_run;

   // lz_mask[j] is set when digit j and every digit above it are zero; digit 0 is never blanked.
   always_comb begin
      lz_run  = 1'b1;
      lz_mask = '0;
      for (int j = 7; j >= 1; j--) begin
         lz_run     = lz_run & (display[j*4 +: 4] == 4'd0);
         lz_mask[j] = lz_run;
      end
   end

   assign blank = lz_mask[idx];
`else
   assign blank = 1'b0;
`endif

   // Next digit select and segments for the current slot; disabled digits stay dark.
   always_comb begin
      dig_nxt  = 8'hFF;
      code_nxt = 7'b0000000;
      if (digit_en[idx]) begin
         dig_nxt[idx] = 1'b0;
         code_nxt     = blank ? 7'b0000000 : seg_decode(cur_code);
      end
   end

   // Output registers; frame_done is delayed one extra stage to line up with the digit-0 DIG update.
   always_ff @(posedge clk_50M) begin
      if (!clear_n) begin
         DIG        <= 8'hFF;
         codeout    <= 7'b0000000;
         frame_done <= 1'b0;
      end else begin
         DIG        <= dig_nxt;
         codeout    <= code_nxt;
         frame_done <= wrap_q;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

   localparam int SCAN_DIV = 4;
`ifdef SEG_LZ_BLANK_EN
   localparam bit LZ_ON = 1'b1;
`else
   localparam bit LZ_ON = 1'b0;
`endif

   logic        clk_50M  = 1'b0;
   logic        clear_n  = 1'b0;
   logic [31:0] bcd_in   = '0;
   logic        load     = 1'b0;
   logic [7:0]  digit_en = 8'hFF;
   logic [7:0]  DIG;
   logic [6:0]  codeout;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int k      = 0;   // edges since last reset release

   seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk_50M    (clk_50M),
      .clear_n    (clear_n),
      .bcd_in     (bcd_in),
      .load       (load),
      .digit_en   (digit_en),
      .DIG        (DIG),
      .codeout    (codeout),
      .frame_done (frame_done)
   );

   always #5 clk_50M = ~clk_50M;

   task automatic tick();
      @(posedge clk_50M);
      #1;
      k++;
   endtask

   function automatic logic [6:0] seg7(input logic [3:0] c);
      case (c)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   // Digit shown after edge k: slots are SCAN_DIV edges long, first slot after release is digit 0.
   function automatic int slot_digit(input int kk);
      return ((kk - 1) / SCAN_DIV) % 8;
   endfunction

   function automatic logic fd_exp(input int kk);
      return (kk > 1) && (((kk - 1) % (8 * SCAN_DIV)) == 0);
   endfunction

   function automatic logic [7:0] dig_exp(input int d, input logic [7:0] en);
      logic [7:0] one;
      one = 8'b1 << d;
      return en[d] ? ~one : 8'hFF;
   endfunction

   function automatic logic [6:0] seg_exp(input logic [31:0] disp, input int d, input logic [7:0] en);
      logic [31:0] upper;
      logic [3:0]  c;
      upper = disp >> (4 * d);
      c     = upper[3:0];
      if (!en[d]) return 7'b0000000;
      if (LZ_ON && d > 0 && upper == 32'd0) return 7'b0000000;
      return seg7(c);
   endfunction

   task automatic test_reset();
      int d;
      clear_n  = 1'b0;
      load     = 1'b1;
      bcd_in   = 32'h99999999;
      digit_en = 8'hFF;
      repeat (3) tick();
      checks++; if (DIG !== 8'hFF) begin errors++; $display("FAIL reset_dig got %h want ff", DIG); end
      checks++; if (codeout !== 7'b0) begin errors++; $display("FAIL reset_code got %b want 0000000", codeout); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
      load    = 1'b0;
      clear_n = 1'b1;
      k       = 0;
      // The load seen during reset must not reach the display at the first boundary.
      while (k < 33) begin
         tick();
         d = slot_digit(k);
         checks++; if (DIG !== dig_exp(d, 8'hFF)) begin errors++; $display("FAIL reset_scan_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'hFF)); end
         checks++; if (codeout !== seg_exp(32'h0, d, 8'hFF)) begin errors++; $display("FAIL reset_scan_code k=%0d got %b want %b", k, codeout, seg_exp(32'h0, d, 8'hFF)); end
         checks++; if (frame_done !== fd_exp(k)) begin errors++; $display("FAIL reset_scan_fd k=%0d got %b want %b", k, frame_done, fd_exp(k)); end
      end
   endtask

   task automatic test_scan();
      int d;
      load   = 1'b1;
      bcd_in = 32'h76543210;
      tick();
      load   = 1'b0;
      while (k < 64) tick();
      while (k < 97) begin
         tick();
         d = slot_digit(k);
         checks++; if (DIG !== dig_exp(d, 8'hFF)) begin errors++; $display("FAIL scan_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'hFF)); end
         checks++; if (codeout !== seg_exp(32'h76543210, d, 8'hFF)) begin errors++; $display("FAIL scan_code k=%0d got %b want %b", k, codeout, seg_exp(32'h76543210, d, 8'hFF)); end
         checks++; if (frame_done !== fd_exp(k)) begin errors++; $display("FAIL scan_fd k=%0d got %b want %b", k, frame_done, fd_exp(k)); end
      end
   endtask

   task automatic test_tear_free();
      int d;
      logic [31:0] disp;
      while (k < 108) tick();
      load   = 1'b1;
      bcd_in = 32'h11111111;
      while (k < 160) begin
         tick();
         load = 1'b0;
         d    = slot_digit(k);
         disp = (k <= 128) ? 32'h76543210 : 32'h11111111;
         checks++; if (DIG !== dig_exp(d, 8'hFF)) begin errors++; $display("FAIL tear_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'hFF)); end
         checks++; if (codeout !== seg_exp(disp, d, 8'hFF)) begin errors++; $display("FAIL tear_code k=%0d got %b want %b", k, codeout, seg_exp(disp, d, 8'hFF)); end
      end
   endtask

   task automatic test_mask_dash();
      int d;
      load   = 1'b1;
      bcd_in = 32'hFFFFFFFA;
      tick();
      load   = 1'b0;
      while (k < 192) tick();
      digit_en = 8'h0F;
      while (k < 223) begin
         tick();
         d = slot_digit(k);
         checks++; if (DIG !== dig_exp(d, 8'h0F)) begin errors++; $display("FAIL mask_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'h0F)); end
         checks++; if (codeout !== seg_exp(32'hFFFFFFFA, d, 8'h0F)) begin errors++; $display("FAIL mask_code k=%0d got %b want %b", k, codeout, seg_exp(32'hFFFFFFFA, d, 8'h0F)); end
      end
   endtask

   task automatic test_coincident_load();
      int d;
      // Load captured on edge 224, which is the index-7 terminal count.
      digit_en = 8'hFF;
      load     = 1'b1;
      bcd_in   = 32'h98765432;
      tick();
      load     = 1'b0;
      while (k < 256) begin
         tick();
         d = slot_digit(k);
         checks++; if (DIG !== dig_exp(d, 8'hFF)) begin errors++; $display("FAIL coin_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'hFF)); end
         checks++; if (codeout !== seg_exp(32'h98765432, d, 8'hFF)) begin errors++; $display("FAIL coin_code k=%0d got %b want %b", k, codeout, seg_exp(32'h98765432, d, 8'hFF)); end
         checks++; if (frame_done !== fd_exp(k)) begin errors++; $display("FAIL coin_fd k=%0d got %b want %b", k, frame_done, fd_exp(k)); end
      end
   endtask

   task automatic test_leading_zero();
      int d;
      logic [6:0] want;
      load   = 1'b1;
      bcd_in = 32'h00000305;
      tick();
      load   = 1'b0;
      while (k < 288) tick();
      while (k < 320) begin
         tick();
         d = slot_digit(k);
         case (d)
            0:       want = 7'b1011011;
            1:       want = 7'b1111110;
            2:       want = 7'b1111001;
            default: want = LZ_ON ? 7'b0000000 : 7'b1111110;
         endcase
         checks++; if (DIG !== dig_exp(d, 8'hFF)) begin errors++; $display("FAIL lz_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'hFF)); end
         checks++; if (codeout !== want) begin errors++; $display("FAIL lz_code k=%0d got %b want %b", k, codeout, want); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int d;
      load   = 1'b1;
      bcd_in = 32'h88888888;
      tick();
      load   = 1'b0;
      while (k < 330) tick();
      clear_n = 1'b0;
      repeat (2) tick();
      checks++; if (DIG !== 8'hFF) begin errors++; $display("FAIL midrst_dig got %h want ff", DIG); end
      checks++; if (codeout !== 7'b0) begin errors++; $display("FAIL midrst_code got %b want 0000000", codeout); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd got %b want 0", frame_done); end
      clear_n = 1'b1;
      k       = 0;
      while (k < 33) begin
         tick();
         d = slot_digit(k);
         checks++; if (DIG !== dig_exp(d, 8'hFF)) begin errors++; $display("FAIL midrst_scan_dig k=%0d got %h want %h", k, DIG, dig_exp(d, 8'hFF)); end
         checks++; if (codeout !== seg_exp(32'h0, d, 8'hFF)) begin errors++; $display("FAIL midrst_scan_code k=%0d got %b want %b", k, codeout, seg_exp(32'h0, d, 8'hFF)); end
         checks++; if (frame_done !== fd_exp(k)) begin errors++; $display("FAIL midrst_scan_fd k=%0d got %b want %b", k, frame_done, fd_exp(k)); end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tear_free();
      test_mask_dash();
      test_coincident_load();
      test_leading_zero();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
